// File: rtl/dma_priority_timing_ctrl.sv
// Channel arbiter and transfer sequencer for an 8237A-style DMA controller:
// request masking, fixed/rotating priority, HRQ/HLDA handshake and SI..S4 timing.
module dma_priority_timing_ctrl #(
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned NUM_CH      = 4
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic [NUM_CH-1:0] REQ_REG,
    input  logic [NUM_CH-1:0] MASK_REG,
    input  logic              CMD_DISABLE,
    input  logic              CMD_ROTATE,
    input  logic              DREQ_SENSE_LOW,
    input  logic              DACK_SENSE_HIGH,
    input  logic [7:0]        MODE_SEL,
    input  logic              HLDA,
    input  logic              TC_IN,
    input  logic              EOP_N,
    input  logic              STATUS_RD,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    output logic              AEN,
    output logic [1:0]        ACTIVE_CH,
    output logic              XFER_STB,
    output logic [NUM_CH-1:0] TC_STATUS,
    output logic              EOP_OUT_N
);

    generate
        if (NUM_CH != 4) begin : g_bad_num_ch
            $error("dma_priority_timing_ctrl: NUM_CH must be 4");
        end
        if (WAIT_STATES > 7) begin : g_bad_wait_states
            $error("dma_priority_timing_ctrl: WAIT_STATES must be 0..7");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_SI,
        ST_S0,
        ST_S1,
        ST_S2,
        ST_S3,
        ST_S4
    } state_t;

    typedef enum logic [1:0] {
        MODE_DEMAND = 2'b00,
        MODE_SINGLE = 2'b01,
        MODE_BLOCK  = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_t;

    localparam logic [2:0] WAIT_LAST = 3'(WAIT_STATES);

    state_t      state;
    logic [3:0]  dack_act;
    logic [1:0]  ptr;
    logic [2:0]  wait_cnt;

    logic [3:0]  eff;
    logic [1:0]  winner;
    logic [1:0]  base;
    logic [1:0]  idx;
    logic        found;
    mode_t       cur_mode;
    logic        end_cond;
    logic        cont;
    logic        hold_lost;
    logic        tc_set;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        eff    = ((DREQ ^ {NUM_CH{DREQ_SENSE_LOW}}) | REQ_REG) & ~MASK_REG;
        base   = CMD_ROTATE ? ptr : 2'd0;
        winner = 2'd0;
        found  = 1'b0;
        idx    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = base + 2'(i);
            if (!found && eff[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        cur_mode  = mode_t'(MODE_SEL[{ACTIVE_CH, 1'b0} +: 2]);
        end_cond  = TC_IN | ~EOP_N | CMD_DISABLE;
        hold_lost = !HLDA && (state inside {ST_S1, ST_S2, ST_S3, ST_S4});
        tc_set    = (state == ST_S4) && HLDA && TC_IN;
        case (cur_mode)
            MODE_DEMAND: cont = !end_cond && eff[ACTIVE_CH];
            MODE_BLOCK:  cont = !end_cond;
            default:     cont = 1'b0;
        endcase
    end

    // EOP must coincide with the S4 cycle in which the datapath reports rollover.
    assign EOP_OUT_N = ~tc_set;
    assign DACK      = DACK_SENSE_HIGH ? dack_act : ~dack_act;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= ST_SI;
            HRQ       <= 1'b0;
            AEN       <= 1'b0;
            ACTIVE_CH <= 2'd0;
            XFER_STB  <= 1'b0;
            dack_act  <= '0;
            ptr       <= 2'd0;
            wait_cnt  <= 3'd0;
        end else begin
            XFER_STB <= 1'b0;
            if (hold_lost) begin
                state    <= ST_SI;
                HRQ      <= 1'b0;
                AEN      <= 1'b0;
                dack_act <= '0;
            end else begin
                case (state)
                    ST_SI: begin
                        if (!CMD_DISABLE && |eff) begin
                            state <= ST_S0;
                            HRQ   <= 1'b1;
                        end
                    end
                    ST_S0: begin
                        if (~|eff) begin
                            state <= ST_SI;
                            HRQ   <= 1'b0;
                        end else if (HLDA) begin
                            state     <= ST_S1;
                            ACTIVE_CH <= winner;
                            dack_act  <= 4'b0001 << winner;
                            AEN       <= 1'b1;
                        end
                    end
                    ST_S1: state <= ST_S2;
                    ST_S2: begin
                        state    <= ST_S3;
                        wait_cnt <= 3'd0;
                    end
                    ST_S3: begin
                        if (wait_cnt == WAIT_LAST) begin
                            state    <= ST_S4;
                            XFER_STB <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + 3'd1;
                        end
                    end
                    ST_S4: begin
                        if (cont) begin
                            state <= ST_S1;
                        end else begin
                            state    <= ST_SI;
                            HRQ      <= 1'b0;
                            AEN      <= 1'b0;
                            dack_act <= '0;
                            if (CMD_ROTATE) ptr <= ACTIVE_CH + 2'd1;
                        end
                    end
                    default: state <= ST_SI;
                endcase
            end
        end
    end

    // A rollover in S4 outranks a same-cycle status-read clear for that channel only.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            TC_STATUS <= '0;
        end else begin
            TC_STATUS <= (STATUS_RD ? '0 : TC_STATUS) | (tc_set ? (4'b0001 << ACTIVE_CH) : '0);
        end
    end

endmodule

// File: tb/tb_dma_priority_timing_ctrl.sv
// Directed bench for dma_priority_timing_ctrl; a scoreboard queue holds the channel
// expected for each XFER_STB, instance b covers the wait-state/sense-polarity cases.
module tb_dma_priority_timing_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] dreq = '0;
    logic [3:0] req_reg = '0;
    logic [3:0] mask_reg = '0;
    logic       cmd_disable = 1'b0;
    logic       cmd_rotate = 1'b0;
    logic       dreq_sense_low = 1'b0;
    logic       dack_sense_high = 1'b0;
    logic [7:0] mode_sel = 8'h55;
    logic       hlda_a = 1'b0;
    logic       hlda_b = 1'b0;
    logic       tc_in = 1'b0;
    logic       eop_n = 1'b1;
    logic       status_rd = 1'b0;
    logic       use_b = 1'b0;

    logic       hrq_a, aen_a, xfer_stb_a, eop_out_n_a;
    logic [3:0] dack_a, tc_status_a;
    logic [1:0] active_ch_a;
    logic       hrq_b, aen_b, xfer_stb_b, eop_out_n_b;
    logic [3:0] dack_b, tc_status_b;
    logic [1:0] active_ch_b;

    wire        hrq_m       = use_b ? hrq_b       : hrq_a;
    wire        aen_m       = use_b ? aen_b       : aen_a;
    wire        xfer_m      = use_b ? xfer_stb_b  : xfer_stb_a;
    wire        eop_m       = use_b ? eop_out_n_b : eop_out_n_a;
    wire  [3:0] dack_m      = use_b ? dack_b      : dack_a;
    wire  [3:0] tc_m        = use_b ? tc_status_b : tc_status_a;
    wire  [1:0] active_m    = use_b ? active_ch_b : active_ch_a;

    int         errors = 0;
    int         checks = 0;
    int         xfer_count = 0;
    int         tc_at = -1;
    int         eop_lows = 0;
    logic [2:0] sb[$];

    dma_priority_timing_ctrl #(.WAIT_STATES(0), .NUM_CH(4)) dut_a (
        .CLK(clk), .RESET_N(rst_n), .DREQ(dreq), .REQ_REG(req_reg), .MASK_REG(mask_reg),
        .CMD_DISABLE(cmd_disable), .CMD_ROTATE(cmd_rotate), .DREQ_SENSE_LOW(dreq_sense_low),
        .DACK_SENSE_HIGH(dack_sense_high), .MODE_SEL(mode_sel), .HLDA(hlda_a), .TC_IN(tc_in),
        .EOP_N(eop_n), .STATUS_RD(status_rd), .HRQ(hrq_a), .DACK(dack_a), .AEN(aen_a),
        .ACTIVE_CH(active_ch_a), .XFER_STB(xfer_stb_a), .TC_STATUS(tc_status_a),
        .EOP_OUT_N(eop_out_n_a)
    );

    dma_priority_timing_ctrl #(.WAIT_STATES(2), .NUM_CH(4)) dut_b (
        .CLK(clk), .RESET_N(rst_n), .DREQ(dreq), .REQ_REG(req_reg), .MASK_REG(mask_reg),
        .CMD_DISABLE(cmd_disable), .CMD_ROTATE(cmd_rotate), .DREQ_SENSE_LOW(dreq_sense_low),
        .DACK_SENSE_HIGH(dack_sense_high), .MODE_SEL(mode_sel), .HLDA(hlda_b), .TC_IN(tc_in),
        .EOP_N(eop_n), .STATUS_RD(status_rd), .HRQ(hrq_b), .DACK(dack_b), .AEN(aen_b),
        .ACTIVE_CH(active_ch_b), .XFER_STB(xfer_stb_b), .TC_STATUS(tc_status_b),
        .EOP_OUT_N(eop_out_n_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: each strobe pops the channel the stimulus said should be served next.
    // The monitor also models the datapath's word-count rollover on strobe number tc_at.
    always begin
        logic [2:0] exp_ch;
        @(posedge clk);
        #1;
        if (xfer_m) begin
            xfer_count++;
            if (sb.size() > 0) exp_ch = sb.pop_front();
            else exp_ch = 3'd4;
            check("sb_active_ch", {1'b0, active_m}, exp_ch);
            tc_in = (xfer_count == tc_at);
        end else begin
            tc_in = 1'b0;
        end
    end

    always @(negedge clk) if (!eop_m) eop_lows++;

    // Runs until AEN has risen and fallen again; returns at the first cycle back in SI.
    task automatic count_service(output int aen_cyc, output int stb_cyc, output logic [3:0] dack_first);
        bit seen = 1'b0;
        aen_cyc    = 0;
        stb_cyc    = 0;
        dack_first = 4'hx;
        for (int g = 0; g < 60; g++) begin
            tick();
            if (aen_m) begin
                if (!seen) dack_first = dack_m;
                seen = 1'b1;
                aen_cyc++;
                if (xfer_m) stb_cyc++;
            end else if (seen) begin
                break;
            end
        end
    endtask

    task automatic wait_stb(input int n);
        int k = 0;
        for (int g = 0; g < 60 && k < n; g++) begin
            tick();
            if (xfer_m) k++;
        end
        check("stb_reached", k, n);
    endtask

    task automatic wait_aen();
        for (int g = 0; g < 20 && !aen_m; g++) tick();
        check("aen_rise", aen_m, 1);
    endtask

    initial begin
        int         aen_cyc, stb_cyc, eop_base;
        logic [3:0] dack_first;

        #1 rst_n = 1'b0;
        tick();
        check("rst_hrq", hrq_m, 0);
        check("rst_aen", aen_m, 0);
        check("rst_dack", dack_m, 4'hf);
        check("rst_active", active_m, 0);
        check("rst_stb", xfer_m, 0);
        check("rst_tc", tc_m, 0);
        check("rst_eop", eop_m, 1);
        rst_n = 1'b1;
        tick();

        // Single transfer on ch0, HLDA two cycles after HRQ.
        dreq = 4'b0001;
        tick();
        check("s0_hrq", hrq_m, 1);
        check("s0_aen", aen_m, 0);
        tick();
        hlda_a = 1'b1;
        sb.push_back(3'd0);
        count_service(aen_cyc, stb_cyc, dack_first);
        dreq = 4'b0000;
        check("single_len", aen_cyc, 4);
        check("single_stb", stb_cyc, 1);
        check("single_dack", dack_first, 4'b1110);
        check("single_hrq_end", hrq_m, 0);
        check("single_dack_end", dack_m, 4'hf);

        // Fixed priority: ch1 before ch3.
        dreq = 4'b1010;
        sb.push_back(3'd1);
        count_service(aen_cyc, stb_cyc, dack_first);
        check("fixed_dack1", dack_first, 4'b1101);
        dreq = 4'b1000;
        sb.push_back(3'd3);
        count_service(aen_cyc, stb_cyc, dack_first);
        check("fixed_dack3", dack_first, 4'b0111);
        dreq = 4'b0000;

        // Rotating priority with all channels requesting.
        cmd_rotate = 1'b1;
        dreq = 4'b1111;
        foreach (sb[i]) sb.delete(i);
        for (int i = 0; i < 5; i++) sb.push_back(3'(i % 4));
        for (int i = 0; i < 5; i++) begin
            count_service(aen_cyc, stb_cyc, dack_first);
            check("rot_len", aen_cyc, 4);
        end
        dreq = 4'b0000;
        cmd_rotate = 1'b0;
        check("rot_sb_empty", sb.size(), 0);

        // Block mode ch2 with rollover on the third strobe.
        mode_sel = 8'h65;
        dreq = 4'b0100;
        tc_at = xfer_count + 3;
        eop_base = eop_lows;
        for (int i = 0; i < 3; i++) sb.push_back(3'd2);
        count_service(aen_cyc, stb_cyc, dack_first);
        dreq = 4'b0000;
        check("block_stb", stb_cyc, 3);
        check("block_len", aen_cyc, 12);
        check("block_eop_cycles", eop_lows - eop_base, 1);
        check("block_tc", tc_m, 4'b0100);
        status_rd = 1'b1;
        tick();
        status_rd = 1'b0;
        check("tc_clear", tc_m, 0);

        // Demand mode ch0: request removed during the second S4.
        mode_sel = 8'h54;
        dreq = 4'b0001;
        sb.push_back(3'd0);
        sb.push_back(3'd0);
        wait_stb(2);
        dreq = 4'b0000;
        tick();
        check("demand_aen_end", aen_m, 0);
        check("demand_hrq_end", hrq_m, 0);
        check("demand_sb_empty", sb.size(), 0);

        // Demand mode ch0: external EOP during the second S4.
        dreq = 4'b0001;
        sb.push_back(3'd0);
        sb.push_back(3'd0);
        wait_stb(2);
        eop_n = 1'b0;
        tick();
        eop_n = 1'b1;
        dreq = 4'b0000;
        check("eop_aen_end", aen_m, 0);
        check("eop_tc", tc_m, 0);
        check("eop_sb_empty", sb.size(), 0);

        // HLDA lost in S2 aborts without a strobe.
        mode_sel = 8'h55;
        dreq = 4'b0001;
        wait_aen();
        tick();
        hlda_a = 1'b0;
        tick();
        dreq = 4'b0000;
        check("abort_aen", aen_m, 0);
        check("abort_hrq", hrq_m, 0);
        check("abort_dack", dack_m, 4'hf);
        check("abort_stb", xfer_m, 0);
        hlda_a = 1'b1;
        tick();

        // Asynchronous reset in S3.
        dreq = 4'b0001;
        wait_aen();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_hrq", hrq_m, 0);
        check("arst_aen", aen_m, 0);
        check("arst_dack", dack_m, 4'hf);
        check("arst_active", active_m, 0);
        check("arst_eop", eop_m, 1);
        dreq = 4'b0000;
        tick();
        rst_n = 1'b1;
        hlda_a = 1'b0;
        tick();

        // Two wait states, active-low DREQ, active-high DACK on instance b.
        use_b = 1'b1;
        dreq_sense_low = 1'b1;
        dack_sense_high = 1'b1;
        dreq = 4'b0111;
        hlda_b = 1'b1;
        sb.push_back(3'd3);
        count_service(aen_cyc, stb_cyc, dack_first);
        mask_reg = 4'b1000;
        cmd_disable = 1'b1;
        check("ws_len", aen_cyc, 6);
        check("ws_stb", stb_cyc, 1);
        check("ws_dack", dack_first, 4'b1000);
        check("ws_dack_idle_high", dack_m, 4'b0000);
        dack_sense_high = 1'b0;
        #1;
        check("ws_dack_idle_low", dack_m, 4'b1111);
        repeat (3) tick();
        check("masked_hrq", hrq_m, 0);
        check("final_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
